// File: rtl/char_transmitter_pkg.sv
// Shared definitions for the character transmitter and receiver-side logic.
package char_transmitter_pkg;

  localparam int unsigned CHAR_W = 8;
  localparam logic [CHAR_W-1:0] NEWLINE_CHAR = 8'h7E;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/char_transmitter_if.sv
// Character enqueue handshake and transmitter status.
interface char_transmitter_if;
  import char_transmitter_pkg::*;

  logic [CHAR_W-1:0] char_in;
  logic              char_valid;
  logic              send_nl;
  logic              clr;
  logic              busy;
  logic              fifo_empty;
  logic              fifo_full;
  logic              overflow;

  modport master (
    output char_in, char_valid, send_nl, clr,
    input  busy, fifo_empty, fifo_full, overflow
  );

  modport slave (
    input  char_in, char_valid, send_nl, clr,
    output busy, fifo_empty, fifo_full, overflow
  );
endinterface

// File: rtl/char_transmitter_tx_fifo.sv
// Circular character FIFO; clr flushes and overrides a same-cycle push.
module tx_fifo
  import char_transmitter_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr,
  input  logic [CHAR_W-1:0]          wr_data,
  output logic [CHAR_W-1:0]          rd_data_c,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  // A push into a full FIFO still lands when the head is leaving this cycle.
  always_comb begin
    do_push = push && !clr && (!full || pop);
    do_pop  = pop && !clr && !empty;
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (do_push && !do_pop)
      count_d = count_q + CW'(1);
    else if (!do_push && do_pop)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      count_q <= count_d;
      full    <= (count_d == CW'(DEPTH));
      empty   <= (count_d == '0);
      if (clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data_c = mem[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/char_transmitter.sv
// Queued 8N1 UART character transmitter with newline marker and flush.
module char_transmitter
  import char_transmitter_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                clk,
  input  logic                reset,
  char_transmitter_if.slave   tx_if,
  output logic                RsTx
);

  localparam int unsigned BIT_TICKS = CLK_FREQ / BAUD;
  localparam int unsigned TW        = $clog2(BIT_TICKS + 1);
  localparam int unsigned CW        = $clog2(DEPTH) + 1;

  tx_state_e         state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [2:0]        bit_q, bit_d;
  logic [CHAR_W-1:0] shreg_q, shreg_d;
  logic              rs_tx_q, busy_q, overflow_q;

  logic              pop_c, wr_c, avail_c, tick_done_c;
  logic [CHAR_W-1:0] wr_data_c, head_c;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign wr_c      = tx_if.char_valid || tx_if.send_nl;
  assign wr_data_c = tx_if.char_valid ? tx_if.char_in : NEWLINE_CHAR;

  tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_c),
    .pop       (pop_c),
    .clr       (tx_if.clr),
    .wr_data   (wr_data_c),
    .rd_data_c (head_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A flush in the same cycle hides the queue so nothing new is started.
  assign avail_c     = (fifo_count != '0) && !tx_if.clr;
  assign tick_done_c = (tick_q == TW'(BIT_TICKS - 1));

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q + TW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (avail_c) begin
          pop_c   = 1'b1;
          shreg_d = head_c;
          state_d = START;
        end
      end
      START: begin
        if (tick_done_c) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick_done_c) begin
          tick_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick_done_c) begin
          tick_d = '0;
          bit_d  = '0;
          if (avail_c) begin
            pop_c   = 1'b1;
            shreg_d = head_c;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // Line and busy are registered from the current state, one cycle behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_tx_q    <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        START:   rs_tx_q <= 1'b0;
        DATA:    rs_tx_q <= shreg_q[0];
        default: rs_tx_q <= 1'b1;
      endcase
      busy_q <= (state_q != IDLE);
      if (wr_c && !tx_if.clr && fifo_full && !pop_c)
        overflow_q <= 1'b1;
    end
  end

  assign RsTx             = rs_tx_q;
  assign tx_if.busy       = busy_q;
  assign tx_if.fifo_empty = fifo_empty;
  assign tx_if.fifo_full  = fifo_full;
  assign tx_if.overflow   = overflow_q;

endmodule

// File: doc/char_transmitter.md
CHAR_TRANSMITTER -- requirements
Module: char_transmitter

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate; BIT_TICKS = CLK_FREQ/BAUD (integer division).
REQ-003 Parameter DEPTH, default 16, FIFO entries, power of two.
REQ-004 clk  input  1  100 MHz system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 char_in  input  8  ASCII character to enqueue.
REQ-007 char_valid  input  1  single-cycle pulse; enqueue char_in.
REQ-008 send_nl  input  1  single-cycle pulse; enqueue newline marker 8'h7E.
REQ-009 clr  input  1  synchronous flush of queued, not-yet-started characters.
REQ-010 RsTx  output  1  UART serial line, idle high.
REQ-011 busy  output  1  high while a frame is on the line.
REQ-012 fifo_empty  output  1  no characters queued.
REQ-013 fifo_full  output  1  DEPTH characters queued.
REQ-014 overflow  output  1  sticky: a write was dropped because FIFO full.

Function
REQ-015 Frame SHALL be 8N1: start bit 0, data bits LSB first, stop bit 1, each bit exactly BIT_TICKS cycles; frame = 10*BIT_TICKS cycles.
REQ-016 char_valid SHALL have priority over send_nl in the same cycle; send_nl that cycle is ignored.
REQ-017 Write when fifo_full SHALL be dropped, contents unchanged, overflow set to 1 until reset.
REQ-018 FSM states: IDLE, START, DATA, STOP.
REQ-019 IDLE: RsTx=1, busy=0; if FIFO non-empty, pop head into shift register and go START.
REQ-020 Write at edge N into empty FIFO with FSM in IDLE SHALL drive RsTx low after edge N+2 (two-cycle latency).
REQ-021 START -> DATA after BIT_TICKS; DATA -> STOP after 8 bits; STOP -> START (popping same cycle) if FIFO non-empty at end of stop bit, else IDLE; no idle gap between back-to-back frames.
REQ-022 busy SHALL be 1 in START, DATA, STOP; 0 in IDLE.
REQ-023 Simultaneous write and pop SHALL both succeed, occupancy unchanged, including when full (pop frees the slot) and when empty-with-pop-not-possible (write only).
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-025 clr SHALL empty the FIFO next edge; frame in progress completes unchanged; clr wins over a same-cycle write.
REQ-026 Bit counter and tick counter SHALL reset to 0 at each state entry.

Reset
REQ-027 On reset assertion, immediately: RsTx=1, busy=0, fifo_empty=1, fifo_full=0, overflow=0, state IDLE, pointers and counters 0.
REQ-028 Reset mid-frame SHALL abort the frame without completing the stop bit; queued data discarded.
REQ-029 First pop possible on the first rising edge after reset deassertion.

Structure
REQ-030 Shared package SHALL hold NEWLINE_CHAR (8'h7E) and the FSM state encoding, shared with receiver-side logic.
REQ-031 FIFO SHALL be sub-module tx_fifo (DEPTH param, push/pop/clr, full/empty/count); serializer FSM in char_transmitter.

Verification (CLK_FREQ=160, BAUD=10, BIT_TICKS=16, DEPTH=4)
REQ-032 Idle: reset, push 8'h41 -> RsTx low at edge 2 after push, bits 1,0,0,0,0,0,1,0 each 16 cycles, stop high, busy low at cycle 160.
REQ-033 Back-to-back: push 'H','I',send_nl -> three contiguous frames, 480 cycles, last data 8'h7E, no idle gap.
REQ-034 Overflow: 6 pushes in consecutive cycles while idle -> first char sent immediately, 4 queued, 1 dropped, overflow=1, fifo_full=1 one cycle.
REQ-035 Priority: char_valid=1 ('Z') and send_nl=1 same cycle -> only 8'h5A sent.
REQ-036 Reset mid-frame at cycle 50 of a frame -> RsTx=1 same cycle, busy=0, fifo_empty=1, no further frames.
REQ-037 clr during frame with 3 queued -> current frame completes, then IDLE, fifo_empty=1.
